// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART command-to-button decoder.
// Modes, stopwatch states, ASCII commands and output FSM states.
package uart_cmd_pkg;

    localparam logic [1:0] MODE_WATCH     = 2'd0;
    localparam logic [1:0] MODE_STOPWATCH = 2'd1;
    localparam logic [1:0] MODE_SENSOR    = 2'd2;

    localparam logic [1:0] SW_STOP = 2'b00;
    localparam logic [1:0] SW_RUN  = 2'b01;

    localparam logic [7:0] CH_G  = 8'h47;
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [7:0] CH_U  = 8'h55;
    localparam logic [7:0] CH_D  = 8'h44;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;

    function automatic logic [7:0] fold_case(input logic [7:0] b,
                                             input logic en);
        if (en && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with flush; a push into a full
// FIFO is taken when a pop happens in the same cycle.
module cmd_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (flush_i || !full_o || do_pop);
    assign rdata_o = mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            // a push in the flush cycle lands in the emptied queue
            wp_q  <= AW'(do_push);
            rp_q  <= '0;
            cnt_q <= (AW+1)'(do_push);
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[flush_i ? '0 : wp_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_cmd_btn_decoder.sv
// Decodes UART command bytes into per-mode button pulses,
// queued in a FIFO and stretched by a PULSE/GAP output FSM.
module uart_cmd_btn_decoder
    import uart_cmd_pkg::*;
#(
    parameter int BTN_W      = 4,
    parameter int PULSE_LEN  = 1,
    parameter int GAP_LEN    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CASE_FOLD  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    input  logic [1:0]       mode_sel,
    input  logic [1:0]       sw_state,
    output logic [BTN_W-1:0] o_btn,
    output logic             o_cmd_valid,
    output logic             o_cmd_err,
    output logic             o_busy
);

    localparam int CW = $clog2(PULSE_LEN + GAP_LEN + 1) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    btn_q, btn_d;
    logic [1:0]    mode_q;
    logic          valid_q, err_q;

    logic [7:0] ch;
    logic [3:0] vec, rd_vec;
    logic       ign, push, pop, load;
    logic       full, empty, mode_chg;

    assign mode_chg = (mode_sel != mode_q);

    always_comb begin
        ch  = fold_case(rx_data, CASE_FOLD != 0);
        vec = 4'b0000;
        ign = (ch == CH_CR) || (ch == CH_LF);
        unique case (mode_sel)
            MODE_STOPWATCH: begin
                if (ch == CH_G && sw_state == SW_STOP) vec = 4'b0001;
                if (ch == CH_S && sw_state == SW_RUN)  vec = 4'b0001;
                if (ch == CH_C)                        vec = 4'b0010;
            end
            MODE_WATCH: begin
                if (ch == CH_U) vec = 4'b0001;
                if (ch == CH_D) vec = 4'b0010;
                if (ch == CH_L) vec = 4'b0100;
                if (ch == CH_R) vec = 4'b1000;
            end
            MODE_SENSOR: begin
                if (ch == CH_T) vec = 4'b0001;
                if (ch == CH_H) vec = 4'b0010;
            end
            default: vec = 4'b0000;
        endcase
    end

    assign push = rx_done && !ign && (vec != 4'b0000)
               && (!full || pop || mode_chg);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        btn_d   = btn_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: load = !empty;
            PULSE: begin
                if (cnt_q == CW'(PULSE_LEN - 1)) begin
                    if (GAP_LEN != 0) state_d = GAP;
                    else if (!empty)  load    = 1'b1;
                    else              state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_LEN - 1)) begin
                    if (!empty) load    = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = PULSE;
            btn_d   = rd_vec;
        end
        if (mode_chg) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign pop = load && !mode_chg;

    cmd_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (mode_chg),
        .wdata_i (vec),
        .rdata_o (rd_vec),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            btn_q   <= 4'b0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= mode_sel;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            valid_q <= push;
            err_q   <= rx_done && !ign && !push;
            mode_q  <= mode_sel;
        end
    end

    assign o_btn       = BTN_W'((state_q == PULSE) ? btn_q : 4'b0000);
    assign o_cmd_valid = valid_q;
    assign o_cmd_err   = err_q;
    assign o_busy      = !empty || (state_q != IDLE);

endmodule
